pc_dispatch_queue: RTL and testbench

PC_DISPATCH_QUEUE -- requirements
Module: pc_dispatch_queue

---
 rtl/pc_dispatch_queue.sv | 131 +++++++++++++
 tb/tb_pc_dispatch_queue.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_dispatch_queue.sv
// rtl/pc_dispatch_queue.sv - dual-port kernel PC dispatch FIFO with round-robin grant
module pc_dispatch_queue #(
  parameter int          DEPTH    = 16,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tbl_wen,
  input  logic [3:0]               tbl_waddr,
  input  logic [15:0]              tbl_wval,
  input  logic                     queue_wen0,
  input  logic                     queue_wen1,
  input  logic [3:0]               queue_number0,
  input  logic [3:0]               queue_number1,
  input  logic                     request_new_pc0,
  input  logic                     request_new_pc1,
  output logic [15:0]              new_pc0,
  output logic [15:0]              new_pc1,
  output logic [1:0]               idle0,
  output logic [1:0]               idle1,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     done
);
  localparam int AW = $clog2(DEPTH);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;
  typedef logic [AW+1:0] spc_t;

  logic [15:0] tbl [16];
  logic [15:0] mem [DEPTH];
  ptr_t        rptr, wptr, rptr_nxt, wptr_port1;
  logic        pend0, pend1, prefer1;

  logic        want0, want1, g0, g1, acc0, acc1, drop, done_set;
  logic [1:0]  n_pop, n_push;
  spc_t        space;
  logic [15:0] pc0_in, pc1_in, head0, head1;

  // Table reads happen before the same-edge write lands (read-before-write).
  assign pc0_in     = tbl[queue_number0];
  assign pc1_in     = tbl[queue_number1];
  assign rptr_nxt   = rptr + ptr_t'(1);
  assign head0      = mem[rptr];
  assign head1      = mem[rptr_nxt];
  assign want0      = pend0 | request_new_pc0;
  assign want1      = pend1 | request_new_pc1;

  // Grants only see the occupancy registered before this edge.
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (!done) begin
      if (want0 && want1) begin
        if (count >= cnt_t'(2)) begin
          g0 = 1'b1;
          g1 = 1'b1;
        end else if (count != '0) begin
          g0 = !prefer1;
          g1 = prefer1;
        end
      end else if (count != '0) begin
        g0 = want0;
        g1 = want1;
      end
    end
  end

  assign n_pop  = {1'b0, g0} + {1'b0, g1};
  // A pop in the same cycle frees a slot for a push.
  assign space  = spc_t'(DEPTH) - spc_t'(count) + spc_t'(n_pop);
  assign acc0   = queue_wen0 && (space != '0);
  assign acc1   = queue_wen1 && (space >= (acc0 ? spc_t'(2) : spc_t'(1)));
  assign drop   = (queue_wen0 && !acc0) || (queue_wen1 && !acc1);
  assign n_push = {1'b0, acc0} + {1'b0, acc1};
  assign wptr_port1 = wptr + (acc0 ? ptr_t'(1) : ptr_t'(0));
  assign done_set   = !done && pend0 && pend1 && (count == '0) && (n_push == 2'd0);

  always_ff @(posedge clk) begin
    if (!rst && tbl_wen) tbl[tbl_waddr] <= tbl_wval;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (acc0) mem[wptr] <= pc0_in;
      if (acc1) mem[wptr_port1] <= pc1_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rptr     <= '0;
      wptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
      prefer1  <= 1'b0;
      pend0    <= 1'b0;
      pend1    <= 1'b1;
      new_pc0  <= RESET_PC;
      new_pc1  <= 16'h0000;
      idle0    <= 2'd0;
      idle1    <= 2'd1;
    end else begin
      rptr     <= rptr + ptr_t'(n_pop);
      wptr     <= wptr + ptr_t'(n_push);
      count    <= count + cnt_t'(n_push) - cnt_t'(n_pop);
      overflow <= overflow | drop;
      pend0    <= want0 && !g0;
      pend1    <= want1 && !g1;
      if (done_set) done <= 1'b1;

      if (g0 && !g1)  prefer1 <= 1'b1;
      else if (g1)    prefer1 <= 1'b0;

      if (g0) new_pc0 <= head0;
      if (g1) new_pc1 <= g0 ? head1 : head0;

      if (done || done_set) begin
        idle0 <= 2'd2;
        idle1 <= 2'd2;
      end else begin
        if (g0)         idle0 <= 2'd0;
        else if (want0) idle0 <= 2'd1;
        if (g1)         idle1 <= 2'd0;
        else if (want1) idle1 <= 2'd1;
      end
    end
  end
endmodule

// File: tb/tb_pc_dispatch_queue.sv
// tb/tb_pc_dispatch_queue.sv - directed self-checking bench for pc_dispatch_queue
module tb_pc_dispatch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [15:0] RESET_PC = 16'h0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        tbl_wen;
  logic [3:0]  tbl_waddr;
  logic [15:0] tbl_wval;
  logic        queue_wen0, queue_wen1;
  logic [3:0]  queue_number0, queue_number1;
  logic        request_new_pc0, request_new_pc1;
  logic [15:0] new_pc0, new_pc1;
  logic [1:0]  idle0, idle1;
  logic [2:0]  count;
  logic        overflow, done;

  int errors = 0;
  int checks = 0;

  pc_dispatch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .tbl_wen(tbl_wen), .tbl_waddr(tbl_waddr), .tbl_wval(tbl_wval),
    .queue_wen0(queue_wen0), .queue_wen1(queue_wen1),
    .queue_number0(queue_number0), .queue_number1(queue_number1),
    .request_new_pc0(request_new_pc0), .request_new_pc1(request_new_pc1),
    .new_pc0(new_pc0), .new_pc1(new_pc1),
    .idle0(idle0), .idle1(idle1),
    .count(count), .overflow(overflow), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    tbl_wen = 0; tbl_waddr = 0; tbl_wval = 0;
    queue_wen0 = 0; queue_wen1 = 0; queue_number0 = 0; queue_number1 = 0;
    request_new_pc0 = 0; request_new_pc1 = 0;
  endtask

  // Advance one edge and settle; inputs applied before are then withdrawn.
  task automatic tick();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic do_reset();
    rst = 1; tick(); rst = 0;
  endtask

  task automatic write_tbl(input logic [3:0] a, input logic [15:0] v);
    tbl_wen = 1; tbl_waddr = a; tbl_wval = v; tick();
  endtask

  task automatic push0(input logic [3:0] n);
    queue_wen0 = 1; queue_number0 = n;
  endtask

  task automatic push1(input logic [3:0] n);
    queue_wen1 = 1; queue_number1 = n;
  endtask

  logic [15:0] expq[$];
  logic [15:0] e, pcv;
  logic        do_req;
  int          mcount;

  initial begin
    rst = 1;
    clear_inputs();
    tick(); tick();
    rst = 0;

    check("rst_count", count, 0);
    check("rst_new_pc0", new_pc0, RESET_PC);
    check("rst_idle0", idle0, 0);
    check("rst_new_pc1", new_pc1, 0);
    check("rst_idle1", idle1, 1);
    check("rst_overflow", overflow, 0);
    check("rst_done", done, 0);

    write_tbl(4'd1, 16'h0010);
    write_tbl(4'd2, 16'h0020);
    write_tbl(4'd3, 16'h0040);
    write_tbl(4'd4, 16'h0044);
    write_tbl(4'd5, 16'h0055);
    write_tbl(4'd6, 16'h0066);
    write_tbl(4'd7, 16'h0077);
    for (int j = 8; j < 16; j++) write_tbl(4'(j), 16'h1000 + 16'(j));

    // Pending port 1 picks up an entry one edge after it is pushed.
    push0(4'd3); tick();
    check("basic_count_after_push", count, 1);
    check("basic_idle1_waiting", idle1, 1);
    tick();
    check("basic_new_pc1", new_pc1, 16'h0040);
    check("basic_idle1_run", idle1, 0);
    check("basic_count_after_pop", count, 0);

    // Same-edge table write to the pushed index: old value is queued.
    push0(4'd3); tbl_wen = 1; tbl_waddr = 4'd3; tbl_wval = 16'h0099; tick();
    request_new_pc0 = 1; tick();
    check("rbw_new_pc0", new_pc0, 16'h0040);
    check("rbw_count", count, 0);
    push0(4'd3); tick();
    request_new_pc0 = 1; tick();
    check("rbw_new_value", new_pc0, 16'h0099);

    // Round-robin with a single entry and both ports pending.
    do_reset();
    push0(4'd1); request_new_pc0 = 1; tick();
    check("rr_idle0_waiting", idle0, 1);
    check("rr_count1", count, 1);
    tick();
    check("rr_first_port0", new_pc0, 16'h0010);
    check("rr_first_idle0", idle0, 0);
    check("rr_first_idle1", idle1, 1);
    push0(4'd2); request_new_pc0 = 1; tick();
    tick();
    check("rr_second_port1", new_pc1, 16'h0020);
    check("rr_second_idle1", idle1, 0);
    check("rr_second_idle0", idle0, 1);
    check("rr_second_count", count, 0);

    // Overflow at DEPTH=4.
    do_reset();
    push0(4'd1); tick(); tick();
    check("ovf_prep_pc1", new_pc1, 16'h0010);
    push0(4'd4); push1(4'd5); tick();
    push0(4'd6); push1(4'd7); tick();
    check("ovf_full_count", count, 4);
    check("ovf_full_flag", overflow, 0);
    push0(4'd1); request_new_pc0 = 1; tick();
    check("ovf_pushpop_pc0", new_pc0, 16'h0044);
    check("ovf_pushpop_count", count, 4);
    check("ovf_pushpop_flag", overflow, 0);
    push0(4'd2); push1(4'd3); tick();
    check("ovf_drop_count", count, 4);
    check("ovf_drop_flag", overflow, 1);

    // Reset beats a simultaneous push, request and table write.
    rst = 1; push0(4'd4); request_new_pc0 = 1;
    tbl_wen = 1; tbl_waddr = 4'd4; tbl_wval = 16'hBEEF;
    tick(); rst = 0;
    check("rstov_count", count, 0);
    check("rstov_new_pc0", new_pc0, RESET_PC);
    check("rstov_idle0", idle0, 0);
    check("rstov_idle1", idle1, 1);
    check("rstov_overflow", overflow, 0);
    push0(4'd4); tick(); tick();
    check("rstov_table_kept", new_pc1, 16'h0044);
    check("rstov_count_after", count, 0);

    // Many entries through a 4-deep FIFO, wrapping pointers.
    do_reset();
    push0(4'd1); tick(); tick();
    mcount = 0;
    for (int i = 0; i < 2 * DEPTH + 3; i++) begin
      pcv = 16'h1008 + 16'(i % 8);
      do_req = (i % 4 != 0) && (mcount > 0);
      push0(4'(8 + i % 8)); request_new_pc0 = do_req;
      tick();
      if (do_req) begin
        e = expq.pop_front();
        check("wrap_pc", new_pc0, e);
        mcount--;
      end
      expq.push_back(pcv);
      mcount++;
      check("wrap_count", count, mcount);
    end
    for (int k = 0; k < 8 && mcount > 0; k++) begin
      request_new_pc0 = 1; tick();
      e = expq.pop_front();
      mcount--;
      check("drain_pc", new_pc0, e);
      check("drain_count", count, mcount);
    end
    check("drain_empty", count, 0);

    // All work exhausted.
    do_reset();
    request_new_pc0 = 1; tick();
    check("done_not_yet", done, 0);
    check("done_idle0_wait", idle0, 1);
    tick();
    check("done_set", done, 1);
    check("done_idle0", idle0, 2);
    check("done_idle1", idle1, 2);
    push0(4'd5); tick();
    check("done_push_count", count, 1);
    check("done_sticky", done, 1);
    tick();
    check("done_no_grant", count, 1);
    check("done_idle0_hold", idle0, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
